// File: rtl/moving_sum_len_ctrl.sv
// moving_sum_len_ctrl: sequencing controller in front of moving_sum_complex.
// The sample stream passes through with zero latency. A requested window
// length is applied only at a clean boundary: the input packet has completed,
// every issued packet has left the sum, then a one-cycle clear and a settle
// period. warm reports that the window holds a full len samples.
module moving_sum_len_ctrl #(
    parameter int MAX_LEN       = 1023,
    parameter int WIDTH         = 16,
    parameter int DEFAULT_LEN   = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int OUTST_W       = 8,
    parameter int LEN_W         = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               set_stb,
    input  logic [LEN_W-1:0]   set_len,
    output logic               busy,
    input  logic [2*WIDTH-1:0] i_tdata,
    input  logic               i_tlast,
    input  logic               i_tvalid,
    output logic               i_tready,
    output logic [2*WIDTH-1:0] o_tdata,
    output logic               o_tlast,
    output logic               o_tvalid,
    input  logic               o_tready,
    input  logic               sum_tlast_hs,
    output logic [LEN_W-1:0]   ms_len,
    output logic               ms_clear,
    output logic               warm
);

    localparam logic [1:0] ST_PASS   = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST   = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SET_W-1:0] SETTLE_ONE    = SET_W'(1);
    localparam logic [LEN_W-1:0] MAX_LEN_V     = LEN_W'(MAX_LEN);
    localparam logic [LEN_W:0]   MAX_LEN_X     = (LEN_W + 1)'(MAX_LEN);
    localparam logic [LEN_W-1:0] DEFAULT_LEN_V = LEN_W'(DEFAULT_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE       = LEN_W'(1);
    localparam logic [OUTST_W-1:0] OUTST_ONE   = OUTST_W'(1);

    logic [1:0]         state;
    logic               pend;
    logic [LEN_W-1:0]   pend_len;
    logic [LEN_W-1:0]   set_len_clamped;
    logic               pkt_active;
    logic [OUTST_W-1:0] outstanding;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_next;
    logic [SET_W-1:0]   settle_cnt;
    logic               pass_en;
    logic               acc;
    logic               cnt_inc;
    logic               cnt_dec;

    // Stream gating: stall outside PASS and once an update waits at a packet boundary.
    always_comb begin
        pass_en  = (state == ST_PASS) && !(pend && !pkt_active);
        o_tdata  = i_tdata;
        o_tlast  = i_tlast;
        o_tvalid = i_tvalid && pass_en;
        i_tready = o_tready && pass_en;
        acc      = i_tvalid && i_tready;
        cnt_inc  = acc && i_tlast;
        cnt_dec  = sum_tlast_hs;
        busy     = pend || (state != ST_PASS);
    end

    // Requested length clamping and next window fill level.
    always_comb begin
        if (set_len == '0) begin
            set_len_clamped = LEN_ONE;
        end else if ({1'b0, set_len} > MAX_LEN_X) begin
            set_len_clamped = MAX_LEN_V;
        end else begin
            set_len_clamped = set_len;
        end

        if (state == ST_FLUSH) begin
            fill_next = '0;
        end else if (acc && (fill < ms_len)) begin
            fill_next = fill + LEN_ONE;
        end else begin
            fill_next = fill;
        end
    end

    // Update sequencing: PASS -> FLUSH (clear, new len) -> SETTLE -> PASS.
    // The strobe is handled after the state case so a strobe landing in FLUSH
    // becomes the next pending update instead of being lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_PASS;
            pend       <= 1'b0;
            pend_len   <= DEFAULT_LEN_V;
            ms_len     <= DEFAULT_LEN_V;
            ms_clear   <= 1'b0;
            settle_cnt <= '0;
        end else if (clear) begin
            state      <= ST_PASS;
            pend       <= 1'b0;
            ms_clear   <= 1'b1;
            settle_cnt <= '0;
        end else begin
            ms_clear <= 1'b0;
            case (state)
                ST_PASS: begin
                    if (pend && !pkt_active && (outstanding == '0)) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    ms_clear   <= 1'b1;
                    ms_len     <= pend_len;
                    pend       <= 1'b0;
                    settle_cnt <= '0;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_PASS;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_ONE;
                    end
                end
                default: state <= ST_PASS;
            endcase
            if (set_stb) begin
                pend     <= 1'b1;
                pend_len <= set_len_clamped;
            end
        end
    end

    // Packet boundary tracking and count of packets still inside the sum.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pkt_active  <= 1'b0;
            outstanding <= '0;
        end else begin
            if (acc) begin
                pkt_active <= !i_tlast;
            end
            if (cnt_inc && !cnt_dec && (outstanding != '1)) begin
                outstanding <= outstanding + OUTST_ONE;
            end else if (cnt_dec && !cnt_inc && (outstanding != '0)) begin
                outstanding <= outstanding - OUTST_ONE;
            end
        end
    end

    // Window fill level and warm flag, both restarted by FLUSH and clear.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            fill <= '0;
            warm <= 1'b0;
        end else begin
            fill <= fill_next;
            warm <= (fill_next >= ms_len);
        end
    end

endmodule

// File: tb/tb_moving_sum_len_ctrl.sv
// Directed testbench for moving_sum_len_ctrl. A second, small instance
// (MAX_LEN=20) exercises clamping of over-range requested lengths.
module tb_moving_sum_len_ctrl;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        set_stb;
    logic [9:0]  set_len;
    logic        busy;
    logic [31:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic        sum_tlast_hs;
    logic [9:0]  ms_len;
    logic        ms_clear;
    logic        warm;

    logic        set_stb2;
    logic [4:0]  set_len2;
    logic        busy2;
    logic        i_tready2;
    logic [31:0] o_tdata2;
    logic        o_tlast2;
    logic        o_tvalid2;
    logic [4:0]  ms_len2;
    logic        ms_clear2;
    logic        warm2;

    int total = 0;
    int bad   = 0;

    moving_sum_len_ctrl #(
        .MAX_LEN(1023), .WIDTH(16), .DEFAULT_LEN(16), .SETTLE_CYCLES(4), .OUTST_W(8)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .set_stb(set_stb), .set_len(set_len),
        .busy(busy), .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
        .i_tready(i_tready), .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
        .o_tready(o_tready), .sum_tlast_hs(sum_tlast_hs), .ms_len(ms_len),
        .ms_clear(ms_clear), .warm(warm)
    );

    moving_sum_len_ctrl #(
        .MAX_LEN(20), .WIDTH(16), .DEFAULT_LEN(16), .SETTLE_CYCLES(4), .OUTST_W(8)
    ) dut_small (
        .clk(clk), .reset(reset), .clear(clear), .set_stb(set_stb2), .set_len(set_len2),
        .busy(busy2), .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(1'b0),
        .i_tready(i_tready2), .o_tdata(o_tdata2), .o_tlast(o_tlast2), .o_tvalid(o_tvalid2),
        .o_tready(o_tready), .sum_tlast_hs(1'b0), .ms_len(ms_len2),
        .ms_clear(ms_clear2), .warm(warm2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] beat_data(input int k);
        return 32'hC0DE_0000 + 32'(k);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; clear = 1'b0;
        set_stb = 1'b0; set_len = '0; set_stb2 = 1'b0; set_len2 = '0;
        i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = '0;
        o_tready = 1'b1; sum_tlast_hs = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (ms_len !== 10'd16) begin bad++; $display("FAIL reset.ms_len got=%0d exp=16", ms_len); end
        total++; if (ms_clear !== 1'b0) begin bad++; $display("FAIL reset.ms_clear got=%b exp=0", ms_clear); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset.busy got=%b exp=0", busy); end
        total++; if (warm !== 1'b0) begin bad++; $display("FAIL reset.warm got=%b exp=0", warm); end
        total++; if (i_tready !== 1'b1) begin bad++; $display("FAIL reset.i_tready got=%b exp=1", i_tready); end
        total++; if (o_tvalid !== 1'b0) begin bad++; $display("FAIL reset.o_tvalid got=%b exp=0", o_tvalid); end
        total++; if (ms_len2 !== 5'd16) begin bad++; $display("FAIL reset.ms_len_small got=%0d exp=16", ms_len2); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL reset.busy_small got=%b exp=0", busy2); end
    endtask

    task automatic test_stream();
        logic el;
        logic ew;
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            el = (c % 10 == 0);
            ew = (c >= 17);
            i_tvalid = 1'b1; i_tdata = beat_data(c); i_tlast = el;
            #1;
            total++; if (o_tdata !== beat_data(c)) begin bad++; $display("FAIL stream.o_tdata c=%0d got=%h exp=%h", c, o_tdata, beat_data(c)); end
            total++; if (o_tlast !== el) begin bad++; $display("FAIL stream.o_tlast c=%0d got=%b exp=%b", c, o_tlast, el); end
            total++; if (o_tvalid !== 1'b1 || i_tready !== 1'b1) begin bad++; $display("FAIL stream.handshake c=%0d got=%b%b exp=11", c, o_tvalid, i_tready); end
            total++; if (warm !== ew) begin bad++; $display("FAIL stream.warm c=%0d got=%b exp=%b", c, warm, ew); end
            total++; if (ms_len !== 10'd16 || ms_clear !== 1'b0) begin bad++; $display("FAIL stream.len_clear c=%0d got=%0d/%b exp=16/0", c, ms_len, ms_clear); end
            @(negedge clk);
        end
    endtask

    task automatic test_update();
        logic er, ec, eb, ew;
        logic [9:0] elen;
        do_reset();
        for (int c = 1; c <= 32; c++) begin
            i_tvalid = 1'b1; i_tdata = beat_data(c); i_tlast = (c == 10);
            set_stb = (c == 3); set_len = 10'd8; sum_tlast_hs = (c == 15);
            er = (c <= 10) || (c >= 22);
            ec = (c == 18);
            elen = (c >= 18) ? 10'd8 : 10'd16;
            eb = (c >= 4) && (c <= 21);
            ew = (c >= 30);
            #1;
            total++; if (i_tready !== er || o_tvalid !== er) begin bad++; $display("FAIL update.ready c=%0d got=%b/%b exp=%b", c, i_tready, o_tvalid, er); end
            total++; if (ms_clear !== ec) begin bad++; $display("FAIL update.ms_clear c=%0d got=%b exp=%b", c, ms_clear, ec); end
            total++; if (ms_len !== elen) begin bad++; $display("FAIL update.ms_len c=%0d got=%0d exp=%0d", c, ms_len, elen); end
            total++; if (busy !== eb) begin bad++; $display("FAIL update.busy c=%0d got=%b exp=%b", c, busy, eb); end
            total++; if (warm !== ew) begin bad++; $display("FAIL update.warm c=%0d got=%b exp=%b", c, warm, ew); end
            @(negedge clk);
        end
        set_stb = 1'b0; sum_tlast_hs = 1'b0;
    endtask

    task automatic test_latest_wins();
        logic er, ec, eb;
        logic [9:0] elen;
        do_reset();
        for (int c = 1; c <= 24; c++) begin
            i_tvalid = (c <= 10); i_tdata = beat_data(c); i_tlast = (c == 10);
            set_stb = (c == 2) || (c == 5); set_len = (c == 2) ? 10'd100 : 10'd200;
            sum_tlast_hs = (c == 11);
            er = (c <= 10) || (c >= 18);
            ec = (c == 14);
            elen = (c >= 14) ? 10'd200 : 10'd16;
            eb = (c >= 3) && (c <= 17);
            #1;
            total++; if (i_tready !== er) begin bad++; $display("FAIL latest.i_tready c=%0d got=%b exp=%b", c, i_tready, er); end
            total++; if (ms_clear !== ec) begin bad++; $display("FAIL latest.ms_clear c=%0d got=%b exp=%b", c, ms_clear, ec); end
            total++; if (ms_len !== elen) begin bad++; $display("FAIL latest.ms_len c=%0d got=%0d exp=%0d", c, ms_len, elen); end
            total++; if (busy !== eb) begin bad++; $display("FAIL latest.busy c=%0d got=%b exp=%b", c, busy, eb); end
            @(negedge clk);
        end
        set_stb = 1'b0; sum_tlast_hs = 1'b0; i_tvalid = 1'b0;
    endtask

    task automatic test_clamp();
        logic [9:0] req [3];
        logic [9:0] expv [3];
        logic [4:0] req2 [3];
        logic [4:0] exp2 [3];
        int unsigned n;
        req  = '{10'd0, 10'd1023, 10'd7};
        expv = '{10'd1, 10'd1023, 10'd7};
        req2 = '{5'd31, 5'd21, 5'd20};
        exp2 = '{5'd20, 5'd20, 5'd20};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_stb = 1'b1; set_len = req[i];
            @(negedge clk);
            set_stb = 1'b0;
            n = 0;
            while (busy === 1'b1 && n < 20) begin @(negedge clk); n++; end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL clamp.timeout i=%0d got busy=%b exp=0", i, busy); end
            total++; if (ms_len !== expv[i]) begin bad++; $display("FAIL clamp.ms_len req=%0d got=%0d exp=%0d", req[i], ms_len, expv[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            set_stb2 = 1'b1; set_len2 = req2[i];
            @(negedge clk);
            set_stb2 = 1'b0;
            n = 0;
            while (busy2 === 1'b1 && n < 20) begin @(negedge clk); n++; end
            total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL clamp_small.timeout i=%0d got busy=%b exp=0", i, busy2); end
            total++; if (ms_len2 !== exp2[i]) begin bad++; $display("FAIL clamp_small.ms_len req=%0d got=%0d exp=%0d", req2[i], ms_len2, exp2[i]); end
        end
    endtask

    task automatic test_idle_update();
        logic er, ev, ec, eb;
        logic [9:0] elen;
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            i_tvalid = (c >= 2); i_tdata = beat_data(c); i_tlast = 1'b0;
            set_stb = (c == 1); set_len = 10'd32;
            er = (c == 1) || (c >= 8);
            ev = (c >= 8);
            ec = (c == 4);
            elen = (c >= 4) ? 10'd32 : 10'd16;
            eb = (c >= 2) && (c <= 7);
            #1;
            total++; if (i_tready !== er) begin bad++; $display("FAIL idle.i_tready c=%0d got=%b exp=%b", c, i_tready, er); end
            total++; if (o_tvalid !== ev) begin bad++; $display("FAIL idle.o_tvalid c=%0d got=%b exp=%b", c, o_tvalid, ev); end
            total++; if (ms_clear !== ec) begin bad++; $display("FAIL idle.ms_clear c=%0d got=%b exp=%b", c, ms_clear, ec); end
            total++; if (ms_len !== elen) begin bad++; $display("FAIL idle.ms_len c=%0d got=%0d exp=%0d", c, ms_len, elen); end
            total++; if (busy !== eb) begin bad++; $display("FAIL idle.busy c=%0d got=%b exp=%b", c, busy, eb); end
            @(negedge clk);
        end
        set_stb = 1'b0; i_tvalid = 1'b0;
    endtask

    task automatic test_clear_abort();
        logic er, ec, eb;
        logic [9:0] elen;
        do_reset();
        for (int c = 1; c <= 18; c++) begin
            i_tvalid = (c <= 2); i_tdata = beat_data(c); i_tlast = 1'b1;
            set_stb = (c == 3) || (c == 7) || (c == 10);
            set_len = (c == 3) ? 10'd50 : ((c == 7) ? 10'd77 : 10'd24);
            clear = (c == 7);
            er = (c <= 3) || ((c >= 8) && (c <= 10)) || (c >= 17);
            ec = (c == 8) || (c == 13);
            elen = (c >= 13) ? 10'd24 : 10'd16;
            eb = ((c >= 4) && (c <= 7)) || ((c >= 11) && (c <= 16));
            #1;
            total++; if (i_tready !== er) begin bad++; $display("FAIL clear.i_tready c=%0d got=%b exp=%b", c, i_tready, er); end
            total++; if (ms_clear !== ec) begin bad++; $display("FAIL clear.ms_clear c=%0d got=%b exp=%b", c, ms_clear, ec); end
            total++; if (ms_len !== elen) begin bad++; $display("FAIL clear.ms_len c=%0d got=%0d exp=%0d", c, ms_len, elen); end
            total++; if (busy !== eb) begin bad++; $display("FAIL clear.busy c=%0d got=%b exp=%b", c, busy, eb); end
            @(negedge clk);
        end
        clear = 1'b0; set_stb = 1'b0;
    endtask

    task automatic test_backpressure_reset();
        logic er, ev;
        int k;
        int acc_cnt;
        k = 1;
        acc_cnt = 0;
        do_reset();
        for (int c = 1; c <= 24; c++) begin
            reset = (c == 18);
            o_tready = (c % 2 == 1);
            i_tvalid = 1'b1; i_tdata = beat_data(100 + k); i_tlast = (k == 6);
            set_stb = (c == 2); set_len = 10'd40; sum_tlast_hs = (c == 14);
            ev = (c <= 11) || (c >= 19);
            er = (c % 2 == 1) && ev;
            #1;
            total++; if (i_tready !== er) begin bad++; $display("FAIL bp.i_tready c=%0d got=%b exp=%b", c, i_tready, er); end
            total++; if (o_tvalid !== ev) begin bad++; $display("FAIL bp.o_tvalid c=%0d got=%b exp=%b", c, o_tvalid, ev); end
            if (o_tvalid && o_tready) begin
                total++; if (o_tdata !== beat_data(100 + k)) begin bad++; $display("FAIL bp.o_tdata c=%0d got=%h exp=%h", c, o_tdata, beat_data(100 + k)); end
            end
            if (c == 17) begin
                total++; if (ms_clear !== 1'b1 || ms_len !== 10'd40) begin bad++; $display("FAIL bp.flush c=%0d got=%b/%0d exp=1/40", c, ms_clear, ms_len); end
            end
            if (c == 18) begin
                total++; if (acc_cnt !== 6) begin bad++; $display("FAIL bp.beat_count got=%0d exp=6", acc_cnt); end
            end
            if (c == 19) begin
                total++; if (ms_len !== 10'd16) begin bad++; $display("FAIL bp.reset_len got=%0d exp=16", ms_len); end
                total++; if (ms_clear !== 1'b0 || busy !== 1'b0 || warm !== 1'b0) begin bad++; $display("FAIL bp.reset_outs got clr=%b busy=%b warm=%b exp=000", ms_clear, busy, warm); end
            end
            if (i_tvalid && i_tready) begin
                acc_cnt++;
                k++;
            end
            @(negedge clk);
        end
        reset = 1'b0; set_stb = 1'b0; sum_tlast_hs = 1'b0; o_tready = 1'b1;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_len = '0;
        set_stb2 = 1'b0; set_len2 = '0;
        i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = '0;
        o_tready = 1'b1; sum_tlast_hs = 1'b0;
        test_reset();
        test_stream();
        test_update();
        test_latest_wins();
        test_clamp();
        test_idle_update();
        test_clear_abort();
        test_backpressure_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
